// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared definitions for the bit-serial add/subtract sequencer:
//   the sequencer state encoding and the operation codes.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_alu_seq_full_adder.sv
// full_adder
//   One-bit full adder cell; the bit-slice that serial_alu_seq time-shares
//   across every operand bit.
// Ports:
//   S   out  sum bit
//   Car out  carry out
//   A   in   operand A bit
//   B   in   operand B bit
//   C   in   carry in
module full_adder (
    output logic S,
    output logic Car,
    input  logic A,
    input  logic B,
    input  logic C
);

    assign S   = A ^ B ^ C;
    assign Car = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
//   Bit-serial add/subtract sequencer. Captures a WIDTH-bit operand pair with
//   start, walks the bits LSB-first through a single full_adder (one bit per
//   clock), then presents result/cout for a one-cycle done pulse and holds
//   them until the next completion.
// Parameters:
//   WIDTH   operand/result width, 2..32
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request; sampled only in IDLE or DONE
//   op      in   0 = a + b, 1 = a - b
//   a, b    in   operands
//   busy    out  high while bits are being processed
//   done    out  one-cycle completion pulse
//   result  out  sum/difference, modulo 2^WIDTH
//   cout    out  final carry (for subtract: 1 = no borrow)
//   ovf     out  signed overflow; only when SERIAL_ALU_OVF_EN is defined
// Configuration macro: SERIAL_ALU_OVF_EN
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ALU_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic fa_s, fa_car;
    logic last_bit;
    logic accept;

    full_adder u_fa (
        .S   (fa_s),
        .Car (fa_car),
        .A   (a_sh_q[0]),
        .B   (b_sh_q[0]),
        .C   (carry_q)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            // Subtract is a + ~b + 1: invert B and seed the carry with 1.
            a_sh_d  = a;
            b_sh_d  = (op == OP_SUB) ? ~b : b;
            carry_d = op;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_car;
            // Hold on the last bit so the counter never wraps.
            if (!last_bit) cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
                result_d = {fa_s, sum_q[WIDTH-1:1]};
                cout_d   = fa_car;
`ifdef SERIAL_ALU_OVF_EN
                // carry_q is the carry into the MSB during the last bit.
                ovf_d    = carry_q ^ fa_car;
`endif
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ALU_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq
//   Scoreboard bench for serial_alu_seq (WIDTH=4). A reference process
//   tracks when requests are accepted and pushes the arithmetic answer;
//   a monitor checks busy/done every cycle and pops on each done.
module tb_serial_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last_exp;
    int   rem = 0;
    logic busy_exp = 1'b0;
    logic done_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integers.
    function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        exp_t e;
        int ua, ub, sa, sb, r;
        ua = int'(x);
        ub = int'(y);
        sa = x[W-1] ? ua - (1 << W) : ua;
        sb = y[W-1] ? ub - (1 << W) : ub;
        if (!o) begin
            r      = ua + ub;
            e.res  = W'(r);
            e.cout = (r >= (1 << W));
            r      = sa + sb;
        end else begin
            r      = ua - ub;
            e.res  = W'(r);
            e.cout = (ua >= ub);
            r      = sa - sb;
        end
        e.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return e;
    endfunction

    // Reference timing: a request is taken when nothing is in flight;
    // it completes W edges later and done shows for the following cycle.
    initial begin
        last_exp = '{res: '0, cout: 1'b0, ovf: 1'b0};
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                rem      = 0;
                busy_exp = 1'b0;
                done_exp = 1'b0;
                q.delete();
                last_exp = '{res: '0, cout: 1'b0, ovf: 1'b0};
            end else if (rem == 0) begin
                done_exp = 1'b0;
                if (start === 1'b1) begin
                    q.push_back(ref_op(a, b, op));
                    rem = W;
                end
                busy_exp = (rem > 0);
            end else begin
                rem--;
                done_exp = (rem == 0);
                busy_exp = (rem > 0);
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                chk("busy", 32'(busy), 32'(busy_exp));
                chk("done", 32'(done), 32'(done_exp));
                if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 32'(1), 32'(0));
                if (done === 1'b1) begin
                    if (q.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
                    else last_exp = q.pop_front();
                end
                chk("result", 32'(result), 32'(last_exp.res));
                chk("cout", 32'(cout), 32'(last_exp.cout));
`ifdef SERIAL_ALU_OVF_EN
                chk("ovf", 32'(ovf), 32'(last_exp.ovf));
`endif
            end
        end
    end

    // Directed op: latency and constant results.
    task automatic do_dir(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xo,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int n;
        logic got;
        @(posedge clk); #2;
        start = 1'b1; a = xa; b = xb; op = xo;
        @(posedge clk); #2;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
        n = 0; got = 1'b0;
        while (n < W + 4 && !got) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        chk("latency", 32'(n), 32'(W + 1));
        chk("dir_result", 32'(result), 32'(er));
        chk("dir_cout", 32'(cout), 32'(ec));
`ifdef SERIAL_ALU_OVF_EN
        chk("dir_ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) chk("dir_ovf_arg", 32'(eo), 32'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ALU_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        do_dir(4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0);
        do_dir(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);
        do_dir(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
        do_dir(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);

        // start held high with operands changing every cycle, incl. during RUN
        @(posedge clk); #2;
        start = 1'b1;
        for (int i = 0; i < 4 * (W + 1); i++) begin
            a = W'($urandom); b = W'($urandom); op = 1'($urandom);
            @(posedge clk); #2;
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);

        // reset in the second RUN cycle
        #2;
        start = 1'b1; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ALU_OVF_EN
        chk("abort_ovf", 32'(ovf), 32'(0));
`endif
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (W + 3) @(posedge clk);
        do_dir(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom); b = W'($urandom); op = 1'($urandom);
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        chk("drain", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial add/subtract sequencer that time-shares a single `full_adder` cell across all operand bits, one bit per clock. It accepts a WIDTH-bit operand pair and an operation code through a start/done handshake, then walks the operands LSB-first through the adder. It returns the result, carry-out and (optionally) signed overflow. It sits between the ALU's operand registers and the shared adder cell, and is the area-reduced alternative to a ripple-carry chain.

## Interface
- WIDTH, 4, operand and result width in bits; legal values are 2 to 32.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset; forces IDLE and clears every register immediately.
- start  in  1  request pulse or level; sampled only in IDLE or DONE.
- op  in  1  0 = add (a + b), 1 = subtract (a − b); captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse; high only in DONE.
- result  out  WIDTH  sum or difference; holds until the next DONE entry.
- cout  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow; present only with SERIAL_ALU_OVF_EN.

## Operation
- The state machine has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE or DONE, with start=1:
  - Load the A shift register ← a.
  - Load the B shift register ← (op ? ~b : b).
  - Carry register ← op, so subtract is two's-complement add of ~b + 1.
  - Bit counter ← 0; next state is RUN.
- DONE with start=0 returns to IDLE. IDLE with start=0 stays in IDLE.
- Each RUN cycle:
  - The adder receives A = A_sh[0], B = B_sh[0], C = carry.
  - The S output shifts into the MSB of the sum shift register; A_sh and B_sh shift right by one.
  - carry ← Car; counter increments.
- When counter = WIDTH−1, the same edge performs the last bit and moves to DONE.
  - On that edge, result ← the final sum register content and cout ← Car.
- start is ignored during RUN. There is no queueing and no restart.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and does not wrap during legal operation.
- Reset mid-operation aborts the operation:
  - busy, done, result, cout and ovf all go to 0.
  - No done pulse is produced for the aborted request.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0.

## Timing
- start is sampled high at edge E0. Edges E1 through E(WIDTH) each process one bit.
- The edge after the last processed bit enters DONE, so busy is high for exactly WIDTH cycles.
- With WIDTH=4, done is high in cycle 5 after the start edge. Total latency from start to done is WIDTH+1 cycles.
- result, cout and ovf are registered outputs. They change only on the edge entering DONE (or on reset) and are stable while done=1 and afterwards.
- Back-to-back operation: start=1 during DONE is accepted on that edge. busy rises the next cycle with no IDLE gap, giving a throughput of one operation per WIDTH+1 cycles.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - Adds the ovf output and a 1-bit register.
  - The carry into the MSB (the carry register value before the last RUN cycle) is captured.
  - ovf ← c_in_msb XOR Car on DONE entry.
- SERIAL_ALU_OVF_EN undefined: the ovf port, its register and the capture logic are absent.
- All other behaviour is identical in both configurations.

## Structure
- Shared package serial_alu_pkg holds:
  - the state enum: IDLE, RUN, DONE;
  - op encoding constants: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: an instance of the existing `full_adder` (ports S, Car, A, B, C) acts as the bit-slice.
- All sequencing, shift registers and the counter live in serial_alu_seq.

## Test plan
- Add with WIDTH=4: a=0111, b=1001, op=0 → after 5 cycles, done=1, result=0000, cout=1, ovf=0.
- Subtract: a=0101, b=0011, op=1 → result=0010, cout=1. Then a=0011, b=0101 → result=1110, cout=0.
- Overflow (SERIAL_ALU_OVF_EN): a=0111, b=0001, op=0 → result=1000, cout=0, ovf=1. Without the macro, the port is absent and result is identical.
- start held high in RUN with changing a/b → the first operation's result is unaffected. A second operation is accepted only in DONE, and busy is high for 4 cycles per operation.
- Back-to-back: start held high continuously → a done pulse every 5 cycles with correct results each time.
- rst asserted in the 2nd RUN cycle → busy=0 immediately and all outputs 0. No done follows until a new start, which then completes correctly.
